sram_byte_bridge: RTL and testbench
===================================

# sram_byte_bridge

Byte-wide, single-line write-back buffer sitting directly upstream of the SDI SRAM burst controller on the devboard. Converts the F8 core's byte read/write requests into single-word bursts on the controller's en_burst/valid/ready interface. Holds one 32-bit word with tag, valid and dirty bits, so sequential byte accesses within a word cost no SRAM traffic.

## Interface
- ADDRBITS, 17: word-address width, matching the SRAM controller's start_addr width.
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  CPU request strobe.
- req_ready  out  1  bridge can accept a request.
- req_write  in  1  1 = byte write, 0 = byte read.
- req_addr  in  ADDRBITS+2  byte address.
- req_wdata  in  8  write byte.
- rsp_valid  out  1  one-cycle pulse: read data or write ack.
- rsp_rdata  out  8  read byte; 0 for write acks.
- flush  in  1  pulse: write back the dirty line.
- flush_done  out  1  one-cycle pulse when the flush completes.
- mem_ready  in  1  controller idle.
- mem_en_burst  out  1  burst enable.
- mem_write  out  1  burst direction.
- mem_start_addr  out  ADDRBITS  burst word address.
- mem_data_in_valid  out  1  write-word valid.
- mem_data_in_ready  in  1  controller accepts the write word.
- mem_data_in  out  32  write word.
- mem_data_out_valid  in  1  read word ready.
- mem_data_out_ready  out  1  read-word accept.
- mem_data_out  in  32  read word, registered by the controller.

## Operation
- Word address = req_addr[ADDRBITS+1:2]. Lane = req_addr[1:0]. Lane 0 = bits [31:24], because the controller shifts bit 31 out first.
- Hit = line_valid and tag equals the word address.
- Read hit: return the lane byte.
- Write hit: merge the byte into the line, set dirty.
- Miss: if dirty, write back the old line first. Then fill from the new address. Write misses allocate: fill, then merge, then set dirty.
- Flush: if valid and dirty, write back the line and clear dirty; the line stays valid. If clean, pulse flush_done the next cycle.
- States:
  - IDLE: wait for a request or flush.
  - WB_REQ: assert en_burst with write=1 and the old tag; wait for mem_data_in_ready.
  - WB_DATA: present data_in_valid; the handshake completes on ready&valid.
  - WB_END: wait for mem_data_in_ready to rise again, drop en_burst, clear dirty, then wait for mem_ready.
  - RD_REQ: assert en_burst with write=0; wait for mem_data_out_valid. In that cycle drop en_burst and assert data_out_ready for one cycle.
  - RD_CAP: capture mem_data_out on the next cycle; set valid, tag, clean.
  - RESP: complete the original request.
- Bursts are never extended: en_burst is low whenever the controller's ready rises again.
- flush has priority over a request presented in the same cycle.
- A flush arriving while the bridge is busy is latched and serviced on return to IDLE.
- A request arriving while the bridge is busy is not accepted, because req_ready is low.

## Timing
- req_ready = (state == IDLE) and no pending flush. A request is accepted on req_valid & req_ready; address and data are registered on acceptance.
- Hit latency: rsp_valid 1 cycle after acceptance.
- Miss latency: rsp_valid 1 cycle after RD_CAP, plus the write-back time if the line was dirty. No new mem_en_burst is issued until mem_ready is high.
- Reset values:
  - All outputs 0. This includes mem_en_burst, data_in_valid, data_out_ready, rsp_valid, flush_done and req_ready.
  - req_ready rises the first cycle after reset_n deasserts.
  - line_valid=0, dirty=0.
- Reset mid-burst aborts immediately. The controller must be reset alongside; the bridge has no recovery handshake.
- Tag compare uses the full ADDRBITS. Wrap at the top address needs no special case.

## Configuration
- SRAM_BYTE_BRIDGE_STATS_EN defined:
  - Adds outputs hit_count[15:0], miss_count[15:0] and wb_count[15:0].
  - Each counter increments per accepted hit, per accepted miss, and per completed write-back respectively.
  - Counters saturate at 16'hffff and clear on reset.
- SRAM_BYTE_BRIDGE_STATS_EN undefined: these ports and the counter logic are absent.

## Structure
- Shared package: state encoding localparams (IDLE..RESP, 3 bits), the lane-to-bit-slice mapping function, and the SRAM opcode-independent burst direction constants.
- Optional sub-module sram_bridge_line: tag, valid and dirty registers plus the byte-merge datapath. The FSM stays in the top module.

## Test plan
- Reset, read byte 0x00004 -> one read burst at word 1. Model returns 32'hA1B2C3D4; rsp_rdata=8'hA1.
- Then read byte 0x00007 -> rsp_rdata=8'hD4 one cycle after acceptance; no mem_en_burst activity.
- Write 8'h55 to 0x00005, then read 0x00008 -> write-back burst of 32'hA155C3D4 to word 1, then fill of word 2; rsp arrives after both.
- Flush with a dirty line -> one write burst, flush_done pulse, dirty clear. A second flush -> flush_done next cycle, no burst.
- flush and req_valid asserted in the same cycle -> flush is serviced first, and the request is accepted when req_ready next rises.
- reset_n asserted during WB_DATA -> all outputs 0 asynchronously and line_valid=0; the next read misses.

Source files
------------

// File: rtl/sram_byte_bridge_pkg.sv
// Shared types for the SRAM byte bridge: FSM state encoding, burst direction, lane mapping.
// Latency: none (declarations only).
// Backpressure: n/a.
`timescale 1ns/1ps
package sram_byte_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WB_REQ  = 3'd1,
        WB_DATA = 3'd2,
        WB_END  = 3'd3,
        RD_REQ  = 3'd4,
        RD_CAP  = 3'd5,
        RESP    = 3'd6
    } state_t;

    // Burst direction as seen on mem_write; independent of any SRAM opcode.
    localparam logic DIR_READ  = 1'b0;
    localparam logic DIR_WRITE = 1'b1;

    // Lane 0 is the most significant byte because the controller shifts bit 31 out first.
    // The bit offset of a lane is (3 - lane) * 8, i.e. the inverted lane number times 8.
    function automatic logic [4:0] lane_lsb(input logic [1:0] lane);
        return {~lane, 3'b000};
    endfunction

    function automatic logic [7:0] lane_get(input logic [31:0] word, input logic [1:0] lane);
        return word[lane_lsb(lane) +: 8];
    endfunction

endpackage

// File: rtl/sram_bridge_line.sv
// Single cached line: tag, valid and dirty bits plus the byte-merge datapath.
// Latency: fill/merge/clean take effect at the next clock edge.
// Backpressure: none; the owning FSM sequences fill, merge and clean.
`timescale 1ns/1ps
module sram_bridge_line
    import sram_byte_bridge_pkg::*;
#(
    parameter int ADDRBITS = 17
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                fill_en,
    input  logic [31:0]         fill_data,
    input  logic [ADDRBITS-1:0] fill_tag,
    input  logic                merge_en,
    input  logic [1:0]          merge_lane,
    input  logic [7:0]          merge_byte,
    input  logic                clean_en,
    output logic [31:0]         line_data,
    output logic [ADDRBITS-1:0] line_tag,
    output logic                line_valid,
    output logic                line_dirty
);

    // Line storage: a fill replaces the whole word and leaves it clean, a merge dirties it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            line_data  <= '0;
            line_tag   <= '0;
            line_valid <= 1'b0;
            line_dirty <= 1'b0;
        end else begin
            if (fill_en) begin
                line_data  <= fill_data;
                line_tag   <= fill_tag;
                line_valid <= 1'b1;
                line_dirty <= 1'b0;
            end
            if (merge_en) begin
                line_data[lane_lsb(merge_lane) +: 8] <= merge_byte;
                line_dirty <= 1'b1;
            end
            if (clean_en) begin
                line_dirty <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sram_byte_bridge.sv
// Byte read/write front end to the SRAM burst controller with a one-word write-back line.
// Latency: hit responds 1 cycle after accept; miss adds optional write-back plus one fill burst.
// Backpressure: req_ready low while busy or a flush is pending; optional stats via SRAM_BYTE_BRIDGE_STATS_EN.
`timescale 1ns/1ps
module sram_byte_bridge
    import sram_byte_bridge_pkg::*;
#(
    parameter int ADDRBITS = 17
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDRBITS+1:0] req_addr,
    input  logic [7:0]          req_wdata,
    output logic                rsp_valid,
    output logic [7:0]          rsp_rdata,
    input  logic                flush,
    output logic                flush_done,
    input  logic                mem_ready,
    output logic                mem_en_burst,
    output logic                mem_write,
    output logic [ADDRBITS-1:0] mem_start_addr,
    output logic                mem_data_in_valid,
    input  logic                mem_data_in_ready,
    output logic [31:0]         mem_data_in,
    input  logic                mem_data_out_valid,
    output logic                mem_data_out_ready,
    input  logic [31:0]         mem_data_out
`ifdef SRAM_BYTE_BRIDGE_STATS_EN
    ,
    output logic [15:0]         hit_count,
    output logic [15:0]         miss_count,
    output logic [15:0]         wb_count
`endif
);

    state_t              state, state_nxt;
    logic [1:0]          sub, sub_nxt;      // phase within a burst state, cleared on every state change
    logic                started;
    logic                flush_pend;
    logic                op_flush;
    logic                req_write_q;
    logic [ADDRBITS-1:0] req_word_q;
    logic [1:0]          req_lane_q;
    logic [7:0]          req_wdata_q;
    logic                fd_set;
    logic                fill_en, merge_en, clean_en;
    logic [31:0]         line_data;
    logic [ADDRBITS-1:0] line_tag;
    logic                line_valid, line_dirty;
    logic                accept, hit, flush_go;

    sram_bridge_line #(.ADDRBITS(ADDRBITS)) u_line (
        .clk        (clk),
        .reset_n    (reset_n),
        .fill_en    (fill_en),
        .fill_data  (mem_data_out),
        .fill_tag   (req_word_q),
        .merge_en   (merge_en),
        .merge_lane (req_lane_q),
        .merge_byte (req_wdata_q),
        .clean_en   (clean_en),
        .line_data  (line_data),
        .line_tag   (line_tag),
        .line_valid (line_valid),
        .line_dirty (line_dirty)
    );

    // A flush on the input wins over a request in the same cycle, so it also blocks req_ready.
    assign flush_go  = started && (state == IDLE) && (flush || flush_pend);
    assign req_ready = started && (state == IDLE) && !flush_pend && !flush;
    assign accept    = req_valid && req_ready;
    assign hit       = line_valid && (line_tag == req_addr[ADDRBITS+1:2]);

    // Next-state and output decode; every burst output is zero outside its own states.
    always_comb begin
        state_nxt          = state;
        sub_nxt            = sub;
        rsp_valid          = 1'b0;
        rsp_rdata          = 8'h00;
        mem_en_burst       = 1'b0;
        mem_write          = DIR_READ;
        mem_start_addr     = '0;
        mem_data_in_valid  = 1'b0;
        mem_data_in        = 32'h0;
        mem_data_out_ready = 1'b0;
        fill_en            = 1'b0;
        merge_en           = 1'b0;
        clean_en           = 1'b0;
        fd_set             = 1'b0;
        case (state)
            IDLE: begin
                if (flush_go) begin
                    if (line_valid && line_dirty) state_nxt = WB_REQ;
                    else                          fd_set    = 1'b1;
                end else if (accept) begin
                    if (hit)                           state_nxt = RESP;
                    else if (line_valid && line_dirty) state_nxt = WB_REQ;
                    else                               state_nxt = RD_REQ;
                end
            end
            WB_REQ: begin
                // Raise en_burst only once the controller is idle, then hold it.
                mem_en_burst   = sub[0] || mem_ready;
                mem_write      = DIR_WRITE;
                mem_start_addr = line_tag;
                if (mem_en_burst && mem_ready) sub_nxt = 2'd1;
                if (mem_en_burst && mem_data_in_ready) state_nxt = WB_DATA;
            end
            WB_DATA: begin
                mem_en_burst      = 1'b1;
                mem_write         = DIR_WRITE;
                mem_start_addr    = line_tag;
                mem_data_in_valid = 1'b1;
                mem_data_in       = line_data;
                if (mem_data_in_ready) state_nxt = WB_END;
            end
            WB_END: begin
                mem_write      = DIR_WRITE;
                mem_start_addr = line_tag;
                case (sub)
                    2'd0: begin
                        mem_en_burst = 1'b1;
                        if (!mem_data_in_ready) sub_nxt = 2'd1;
                    end
                    2'd1: begin
                        // data_in_ready rising again means the word is out; end the burst now.
                        mem_en_burst = !mem_data_in_ready;
                        if (mem_data_in_ready) begin
                            clean_en = 1'b1;
                            sub_nxt  = 2'd2;
                        end
                    end
                    default: begin
                        if (mem_ready) begin
                            state_nxt = op_flush ? IDLE : RD_REQ;
                            fd_set    = op_flush;
                        end
                    end
                endcase
            end
            RD_REQ: begin
                mem_en_burst   = (sub[0] || mem_ready) && !(sub[0] && mem_data_out_valid);
                mem_write      = DIR_READ;
                mem_start_addr = req_word_q;
                if (mem_en_burst && mem_ready) sub_nxt = 2'd1;
                if (sub[0] && mem_data_out_valid) begin
                    mem_data_out_ready = 1'b1;
                    state_nxt          = RD_CAP;
                end
            end
            RD_CAP: begin
                fill_en   = 1'b1;
                state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_rdata = req_write_q ? 8'h00 : lane_get(line_data, req_lane_q);
                merge_en  = req_write_q;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (state_nxt != state) sub_nxt = 2'd0;
    end

    // State, request capture, flush bookkeeping and the registered flush_done pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            sub         <= 2'd0;
            started     <= 1'b0;
            flush_pend  <= 1'b0;
            op_flush    <= 1'b0;
            req_write_q <= 1'b0;
            req_word_q  <= '0;
            req_lane_q  <= 2'd0;
            req_wdata_q <= 8'h00;
            flush_done  <= 1'b0;
        end else begin
            state      <= state_nxt;
            sub        <= sub_nxt;
            started    <= 1'b1;
            flush_done <= fd_set;
            if (started && state == IDLE) begin
                flush_pend <= 1'b0;
                op_flush   <= flush || flush_pend;
            end else if (flush) begin
                flush_pend <= 1'b1;
            end
            if (accept) begin
                req_write_q <= req_write;
                req_word_q  <= req_addr[ADDRBITS+1:2];
                req_lane_q  <= req_addr[1:0];
                req_wdata_q <= req_wdata;
            end
        end
    end

`ifdef SRAM_BYTE_BRIDGE_STATS_EN
    // Saturating event counters: accepted hits, accepted misses, completed write-backs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_count  <= 16'h0;
            miss_count <= 16'h0;
            wb_count   <= 16'h0;
        end else begin
            if (accept && !flush_go && hit && hit_count != 16'hffff)
                hit_count <= hit_count + 16'h1;
            if (accept && !flush_go && !hit && miss_count != 16'hffff)
                miss_count <= miss_count + 16'h1;
            if (clean_en && wb_count != 16'hffff)
                wb_count <= wb_count + 16'h1;
        end
    end
`endif

endmodule

// File: tb/tb_sram_byte_bridge.sv
// Directed bench for sram_byte_bridge with a behavioural burst-controller model and scoreboards.
// Latency: checks hit and clean-flush timing to the cycle; miss timing is checked for order only.
// Backpressure: requests wait on req_ready with a cycle bound.
`timescale 1ns/1ps
module tb_sram_byte_bridge;

    localparam int AB = 17;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [AB+1:0] req_addr = '0;
    logic [7:0]    req_wdata = 8'h00;
    logic          rsp_valid;
    logic [7:0]    rsp_rdata;
    logic          flush = 1'b0;
    logic          flush_done;
    logic          mem_ready;
    logic          mem_en_burst;
    logic          mem_write;
    logic [AB-1:0] mem_start_addr;
    logic          mem_data_in_valid;
    logic          din_rdy;
    logic [31:0]   mem_data_in;
    logic          dout_vld;
    logic          dout_rdy;
    logic [31:0]   dout;
`ifdef SRAM_BYTE_BRIDGE_STATS_EN
    logic [15:0]   hit_count, miss_count, wb_count;
`endif

    sram_byte_bridge #(.ADDRBITS(AB)) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .req_valid          (req_valid),
        .req_ready          (req_ready),
        .req_write          (req_write),
        .req_addr           (req_addr),
        .req_wdata          (req_wdata),
        .rsp_valid          (rsp_valid),
        .rsp_rdata          (rsp_rdata),
        .flush              (flush),
        .flush_done         (flush_done),
        .mem_ready          (mem_ready),
        .mem_en_burst       (mem_en_burst),
        .mem_write          (mem_write),
        .mem_start_addr     (mem_start_addr),
        .mem_data_in_valid  (mem_data_in_valid),
        .mem_data_in_ready  (din_rdy),
        .mem_data_in        (mem_data_in),
        .mem_data_out_valid (dout_vld),
        .mem_data_out_ready (dout_rdy),
        .mem_data_out       (dout)
`ifdef SRAM_BYTE_BRIDGE_STATS_EN
        ,
        .hit_count          (hit_count),
        .miss_count         (miss_count),
        .wb_count           (wb_count)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Burst controller model: single-word bursts, memory preloaded on reset.
    typedef enum int {M_IDLE, M_WREQ, M_WSHIFT, M_WNEXT, M_RWAIT, M_RDATA, M_END} mst_t;
    mst_t          mst;
    int            mcnt;
    logic [AB-1:0] m_addr;
    logic          m_wr;
    logic [31:0]   mem [0:15];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mst <= M_IDLE; mcnt <= 0; m_addr <= '0; m_wr <= 1'b0;
            mem_ready <= 1'b0; din_rdy <= 1'b0; dout_vld <= 1'b0; dout <= 32'h0;
            for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
            mem[1] <= 32'hA1B2C3D4;
            mem[2] <= 32'h11223344;
            mem[3] <= 32'hDEADBEEF;
        end else begin
            case (mst)
                M_IDLE: begin
                    mem_ready <= 1'b1;
                    if (mem_en_burst && mem_ready) begin
                        mem_ready <= 1'b0;
                        m_addr    <= mem_start_addr;
                        m_wr      <= mem_write;
                        if (mem_write) begin din_rdy <= 1'b1; mst <= M_WREQ; end
                        else begin mcnt <= 2; mst <= M_RWAIT; end
                    end
                end
                M_WREQ: if (mem_data_in_valid && din_rdy) begin
                    mem[m_addr[3:0]] <= mem_data_in;
                    din_rdy <= 1'b0; mcnt <= 3; mst <= M_WSHIFT;
                end
                M_WSHIFT: if (mcnt == 0) begin din_rdy <= 1'b1; mst <= M_WNEXT; end
                          else mcnt <= mcnt - 1;
                M_WNEXT: if (!mem_en_burst) begin din_rdy <= 1'b0; mcnt <= 1; mst <= M_END; end
                M_RWAIT: if (mcnt == 0) begin dout <= mem[m_addr[3:0]]; dout_vld <= 1'b1; mst <= M_RDATA; end
                         else mcnt <= mcnt - 1;
                M_RDATA: if (dout_rdy) begin dout_vld <= 1'b0; mcnt <= 1; mst <= M_END; end
                default: if (mcnt == 0) begin mem_ready <= 1'b1; mst <= M_IDLE; end
                         else mcnt <= mcnt - 1;
            endcase
        end
    end

    typedef struct { logic [7:0] d; int cyc; } rsp_e_t;
    typedef struct { logic wr; logic [AB-1:0] a; logic [31:0] d; } bur_e_t;
    rsp_e_t exp_rsp[$];
    bur_e_t exp_bur[$];
    int     exp_fd[$];
    int     checks = 0;
    int     errors = 0;
    int     en_cnt = 0;
    int     fd_seen = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s got=none exp=event", nm);
    endtask

    function automatic logic [63:0] outs();
        return {req_ready, rsp_valid, rsp_rdata, flush_done, mem_en_burst, mem_write,
                mem_start_addr, mem_data_in_valid, dout_rdy, mem_data_in};
    endfunction

    // Caller is at a negedge; holds the request until accepted and returns the accept cycle.
    task automatic do_req(input logic wr, input logic [AB+1:0] a, input logic [7:0] d, output int acc);
        int n;
        n = 0;
        acc = -1;
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
        #1;
        while (!req_ready && n < 300) begin @(negedge clk); #1; n++; end
        if (!req_ready) begin
            fail("req_accept_timeout");
            req_valid = 1'b0;
        end else begin
            @(posedge clk); #1;
            req_valid = 1'b0;
            acc = cyc;
        end
    endtask

    task automatic do_flush(output int fc);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        fc = cyc;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_rsp.size() != 0 || exp_bur.size() != 0 || exp_fd.size() != 0) && n < 400) begin
            @(negedge clk); n++;
        end
        if (exp_rsp.size() != 0 || exp_bur.size() != 0 || exp_fd.size() != 0) begin
            fail("drain_timeout");
            exp_rsp.delete(); exp_bur.delete(); exp_fd.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int acc, fc, e0, fd0, n;

        // Monitor: pops the scoreboards whenever the DUT presents a response, burst word or flush_done.
        fork
            begin : monitor
                rsp_e_t er;
                bur_e_t eb;
                int     ef;
                forever begin
                    @(negedge clk);
                    if (reset_n) begin
                        if (mem_en_burst) en_cnt++;
                        if (rsp_valid) begin
                            if (exp_rsp.size() == 0) fail("rsp_unexpected");
                            else begin
                                er = exp_rsp.pop_front();
                                chk("rsp_data", {56'h0, rsp_rdata}, {56'h0, er.d});
                                if (er.cyc >= 0) chk("rsp_latency", 64'(cyc), 64'(er.cyc));
                            end
                        end
                        if ((mem_data_in_valid && din_rdy) || (dout_vld && dout_rdy)) begin
                            if (exp_bur.size() == 0) fail("burst_unexpected");
                            else begin
                                eb = exp_bur.pop_front();
                                chk("burst", {m_wr, m_addr, (m_wr ? mem_data_in : 32'h0)},
                                    {eb.wr, eb.a, eb.d});
                            end
                        end
                        if (flush_done) begin
                            fd_seen++;
                            if (exp_fd.size() == 0) fail("flush_done_unexpected");
                            else begin
                                ef = exp_fd.pop_front();
                                if (ef >= 0) chk("flush_done_latency", 64'(cyc), 64'(ef));
                            end
                        end
                    end
                end
            end
        join_none

        // Reset values and the first-cycle rise of req_ready.
        repeat (3) @(negedge clk);
        #1 chk("reset_outputs", outs(), 64'h0);
        @(negedge clk);
        reset_n = 1'b1;
        #1 chk("ready_before_edge", {63'h0, req_ready}, 64'h0);
        @(posedge clk); #1 chk("ready_after_release", {63'h0, req_ready}, 64'h1);
        @(negedge clk);

        // Cold read miss: one read burst of word 1, lane 0.
        exp_bur.push_back('{1'b0, 17'd1, 32'h0});
        do_req(1'b0, 19'h00004, 8'h00, acc);
        exp_rsp.push_back('{8'hA1, -1});
        drain();

        // Read hit on lane 3: one-cycle latency, no burst activity.
        e0 = en_cnt;
        do_req(1'b0, 19'h00007, 8'h00, acc);
        exp_rsp.push_back('{8'hD4, acc});
        drain();
        chk("hit_no_burst", 64'(en_cnt - e0), 64'h0);

        // Write hit dirties the line, then a miss writes it back before filling word 2.
        do_req(1'b1, 19'h00005, 8'h55, acc);
        exp_rsp.push_back('{8'h00, acc});
        drain();
        exp_bur.push_back('{1'b1, 17'd1, 32'hA155C3D4});
        exp_bur.push_back('{1'b0, 17'd2, 32'h0});
        do_req(1'b0, 19'h00008, 8'h00, acc);
        exp_rsp.push_back('{8'h11, -1});
        drain();

        // Dirty flush writes back; a second flush on the clean line answers next cycle.
        do_req(1'b1, 19'h0000A, 8'h66, acc);
        exp_rsp.push_back('{8'h00, acc});
        drain();
        exp_bur.push_back('{1'b1, 17'd2, 32'h11226644});
        exp_fd.push_back(-1);
        do_flush(fc);
        drain();
        e0 = en_cnt;
        do_flush(fc);
        exp_fd.push_back(fc);
        drain();
        chk("clean_flush_no_burst", 64'(en_cnt - e0), 64'h0);

        // Flush and request in the same cycle: flush completes before the request is taken.
        do_req(1'b1, 19'h00008, 8'h77, acc);
        exp_rsp.push_back('{8'h00, acc});
        drain();
        exp_bur.push_back('{1'b1, 17'd2, 32'h77226644});
        exp_bur.push_back('{1'b0, 17'd3, 32'h0});
        exp_fd.push_back(-1);
        fd0 = fd_seen;
        flush = 1'b1;
        fork
            begin
                @(posedge clk); #1;
                flush = 1'b0;
            end
        join_none
        do_req(1'b0, 19'h0000C, 8'h00, acc);
        chk("flush_before_req", 64'(fd_seen - fd0), 64'h1);
        exp_rsp.push_back('{8'hDE, -1});
        drain();

        // Reset asserted while the write-back word is on the bus; the next read must miss.
        do_req(1'b1, 19'h0000D, 8'h99, acc);
        exp_rsp.push_back('{8'h00, acc});
        drain();
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        n = 0;
        while (!mem_data_in_valid && n < 50) begin @(posedge clk); #1; n++; end
        if (!mem_data_in_valid) fail("wb_data_timeout");
        reset_n = 1'b0;
        #1 chk("midburst_reset_outputs", outs(), 64'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        exp_bur.push_back('{1'b0, 17'd3, 32'h0});
        do_req(1'b0, 19'h0000D, 8'h00, acc);
        exp_rsp.push_back('{8'hAD, -1});
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
